// File: rtl/branch_resolver.sv
// Tracks in-flight predicted branches in order, checks each against its resolved
// outcome, and raises flush/redirect and predictor updates. Optional counters: BR_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            i_clock,
  input  logic            i_clear,
  input  logic            i_br_push,
  input  logic            i_br_pred_taken,
  input  logic [PC_W-1:0] i_br_pc,
  input  logic [PC_W-1:0] i_br_pred_target,
  output logic            o_br_full,
  input  logic            i_res_valid,
  input  logic            i_res_taken,
  input  logic [PC_W-1:0] i_res_target,
  output logic            o_flush,
  output logic [PC_W-1:0] o_redirect_pc,
  output logic            o_upd_en,
  output logic            o_upd_decision,
  output logic            o_res_err
`ifdef BR_RESOLVER_STATS_EN
  ,
  output logic [15:0]     o_stat_resolved,
  output logic [15:0]     o_stat_mispred
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic              r_ent_taken  [DEPTH];
  logic [PC_W-1:0]   r_ent_pc     [DEPTH];
  logic [PC_W-1:0]   r_ent_target [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_flush;
  logic [PC_W-1:0]   r_redirect_pc;
  logic              r_upd_en;
  logic              r_upd_decision;
  logic              r_res_err;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_mispred;
  logic              w_push_ok;
  logic              w_head_taken;
  logic [PC_W-1:0]   w_head_pc;
  logic [PC_W-1:0]   w_head_target;
  logic [PC_W-1:0]   w_redirect;

  // Head decode and mispredict detection
  always_comb begin
    w_empty       = (r_count == '0);
    w_full        = (r_count == CNT_W'(DEPTH));
    w_head_taken  = r_ent_taken[r_rd_ptr];
    w_head_pc     = r_ent_pc[r_rd_ptr];
    w_head_target = r_ent_target[r_rd_ptr];
    w_pop         = i_res_valid && !w_empty;
    w_mispred     = w_pop && ((i_res_taken != w_head_taken) ||
                              (i_res_taken && (i_res_target != w_head_target)));
    // A push younger than a mispredicting branch is discarded with the squash
    w_push_ok     = i_br_push && !w_mispred && (!w_full || w_pop);
    w_redirect    = i_res_taken ? i_res_target : (w_head_pc + PC_W'(4));
  end

  // Entry storage carries no reset
  always_ff @(posedge i_clock) begin
    if (w_push_ok) begin
      r_ent_taken[r_wr_ptr]  <= i_br_pred_taken;
      r_ent_pc[r_wr_ptr]     <= i_br_pc;
      r_ent_target[r_wr_ptr] <= i_br_pred_target;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_mispred) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    end
  end

  // Registered resolution outputs, one-cycle pulses
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_flush        <= 1'b0;
      r_redirect_pc  <= '0;
      r_upd_en       <= 1'b0;
      r_upd_decision <= 1'b0;
      r_res_err      <= 1'b0;
    end else begin
      r_flush        <= w_mispred;
      r_upd_en       <= w_pop;
      r_upd_decision <= w_pop && i_res_taken;
      r_res_err      <= i_res_valid && w_empty;
      if (w_mispred) r_redirect_pc <= w_redirect;
    end
  end

  assign o_br_full      = w_full;
  assign o_flush        = r_flush;
  assign o_redirect_pc  = r_redirect_pc;
  assign o_upd_en       = r_upd_en;
  assign o_upd_decision = r_upd_decision;
  assign o_res_err      = r_res_err;

`ifdef BR_RESOLVER_STATS_EN
  logic [15:0] r_stat_resolved;
  logic [15:0] r_stat_mispred;

  // Saturating event counters
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_pop && (r_stat_resolved != 16'hFFFF))
        r_stat_resolved <= r_stat_resolved + 16'd1;
      if (w_mispred && (r_stat_mispred != 16'hFFFF))
        r_stat_mispred <= r_stat_mispred + 16'd1;
    end
  end

  assign o_stat_resolved = r_stat_resolved;
  assign o_stat_mispred  = r_stat_mispred;
`endif

endmodule
